// File: rtl/alu_seq_fsm.sv
// Sequencer that drives register-file / I0 bus / ALU enables through a fixed
// read-latch-release pattern for one ALU operation per launch.
module alu_seq_fsm #(
    parameter int              ADDR_W     = 6,
    parameter int              OP_W       = 4,
    parameter int              NUM_REGS   = 4,
    parameter logic [3:0]      START_CODE = 4'b0010,
    parameter logic [OP_W-1:0] IDLE_OP    = '1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        FSM_start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] param1,
    input  logic [ADDR_W-1:0] param2,
    input  logic [ADDR_W-1:0] param3,
    input  logic              dest_sel,
    input  logic              unary,
    input  logic              abort,
    output logic              bus_register_out_en,
    output logic              bus_register_input_en,
    output logic              I0_bus_output_en,
    output logic              I0_bus_input_en,
    output logic              latched_bus1_en,
    output logic              latched_bus2_en,
    output logic              alu_bus_out_en,
    output logic [ADDR_W-1:0] register_addr,
    output logic [OP_W-1:0]   alu_control,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD1  = 4'd1,
        LAT1 = 4'd2,
        REL1 = 4'd3,
        RD2  = 4'd4,
        LAT2 = 4'd5,
        REL2 = 4'd6,
        EXE  = 4'd7,
        WB   = 4'd8,
        REL3 = 4'd9,
        DONE = 4'd10
    } state_t;

    localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

    state_t            state_reg, state_next;
    logic [OP_W-1:0]   op_reg;
    logic [ADDR_W-1:0] p1_reg, p2_reg, p3_reg;
    logic              dest_sel_reg, unary_reg;
    logic              launch;
    logic [ADDR_W-1:0] src_addr, dest_addr;

    assign launch    = (state_reg == IDLE) && (FSM_start == START_CODE);
    assign src_addr  = (state_reg == RD1 || state_reg == LAT1) ? p1_reg : p2_reg;
    assign dest_addr = dest_sel_reg ? p3_reg : p1_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            p1_reg       <= '0;
            p2_reg       <= '0;
            p3_reg       <= '0;
            dest_sel_reg <= 1'b0;
            unary_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                op_reg       <= opcode;
                p1_reg       <= param1;
                p2_reg       <= param2;
                p3_reg       <= param3;
                dest_sel_reg <= dest_sel;
                unary_reg    <= unary;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = launch ? RD1 : IDLE;
            RD1:     state_next = LAT1;
            LAT1:    state_next = REL1;
            REL1:    state_next = unary_reg ? EXE : RD2;
            RD2:     state_next = LAT2;
            LAT2:    state_next = REL2;
            REL2:    state_next = EXE;
            EXE:     state_next = WB;
            WB:      state_next = REL3;
            REL3:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort only cancels work in flight; a launch from IDLE still proceeds.
        if (state_reg != IDLE && abort) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        bus_register_out_en   = 1'b0;
        bus_register_input_en = 1'b0;
        I0_bus_output_en      = 1'b0;
        I0_bus_input_en       = 1'b0;
        latched_bus1_en       = 1'b0;
        latched_bus2_en       = 1'b0;
        alu_bus_out_en        = 1'b0;
        register_addr         = '0;
        alu_control           = IDLE_OP;
        busy                  = (state_reg != IDLE);
        done                  = (state_reg == DONE);
        case (state_reg)
            RD1, LAT1, RD2, LAT2: begin
                if (src_addr < REG_LIMIT) begin
                    register_addr       = src_addr;
                    bus_register_out_en = 1'b1;
                end else begin
                    I0_bus_output_en = 1'b1;
                end
                latched_bus1_en = (state_reg == LAT1);
                latched_bus2_en = (state_reg == LAT2);
            end
            EXE: alu_bus_out_en = 1'b1;
            WB: begin
                alu_bus_out_en = 1'b1;
                if (dest_addr < REG_LIMIT) begin
                    register_addr         = dest_addr;
                    bus_register_input_en = 1'b1;
                end else begin
                    I0_bus_input_en = 1'b1;
                end
            end
            default: ;
        endcase
        // Opcode is presented from the first latch through write-back.
        case (state_reg)
            LAT1, REL1, RD2, LAT2, REL2, EXE, WB: alu_control = op_reg;
            default: ;
        endcase
    end

endmodule

// File: doc/alu_seq_fsm.md
ALU_SEQ_FSM -- requirements
Module: alu_seq_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of param1/param2/param3/register_addr.
REQ-002 SHALL have parameter OP_W, default 4, width of opcode/alu_control.
REQ-003 SHALL have parameter NUM_REGS, default 4; an address < NUM_REGS selects a register, an address >= NUM_REGS selects the I0 bus.
REQ-004 SHALL have parameter START_CODE, default 4'b0010, FSM_start value that launches an operation.
REQ-005 SHALL have parameter IDLE_OP, default all ones (OP_W bits), alu_control value while not executing.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 FSM_start  input  4  launch code, sampled in IDLE only.
REQ-009 opcode  input  OP_W  ALU operation, captured at launch.
REQ-010 param1 / param2 / param3  input  ADDR_W each  source 1, source 2, destination, captured at launch.
REQ-011 dest_sel  input  1  captured at launch; 0 = write back to param1, 1 = write back to param3.
REQ-012 unary  input  1  captured at launch; 1 = skip source-2 fetch.
REQ-013 abort  input  1  synchronous cancel of an operation in progress.
REQ-014 bus_register_out_en, bus_register_input_en, I0_bus_output_en, I0_bus_input_en, latched_bus1_en, latched_bus2_en, alu_bus_out_en  output  1 each  bus/latch enables.
REQ-015 register_addr  output  ADDR_W  register file address; alu_control  output  OP_W  ALU op.
REQ-016 busy  output  1  high in every state except IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, RD1, LAT1, REL1, RD2, LAT2, REL2, EXE, WB, REL3, DONE, and all outputs SHALL be decoded from the state register plus captured fields only.
REQ-018 IDLE -> RD1 SHALL occur on a clock edge with FSM_start == START_CODE; opcode, params, dest_sel and unary SHALL be captured on that same edge.
REQ-019 Sequence SHALL be RD1->LAT1->REL1->RD2->LAT2->REL2->EXE->WB->REL3->DONE->IDLE; with unary=1, REL1 SHALL go directly to EXE.
REQ-020 In RD1 and LAT1, a source-1 address < NUM_REGS SHALL drive register_addr=src1 and bus_register_out_en=1.
REQ-021 In RD1 and LAT1, a source-1 address >= NUM_REGS SHALL drive I0_bus_output_en=1, with register_addr=0 and bus_register_out_en=0.
REQ-022 RD2 and LAT2 SHALL drive source 2 by the same rules as REQ-020 and REQ-021.
REQ-023 latched_bus1_en SHALL be 1 only in LAT1, and latched_bus2_en SHALL be 1 only in LAT2.
REQ-024 REL1, REL2 and REL3 SHALL deassert every enable.
REQ-025 EXE and WB SHALL assert alu_bus_out_en, with dest = dest_sel ? param3 : param1.
REQ-026 WB with dest < NUM_REGS SHALL drive register_addr=dest and bus_register_input_en=1.
REQ-027 WB with dest >= NUM_REGS SHALL drive I0_bus_input_en=1 and register_addr=0.
REQ-028 alu_control SHALL equal the captured opcode from LAT1 through WB inclusive, and IDLE_OP otherwise.
REQ-029 done SHALL be 1 only in DONE; latency from launch edge to done high SHALL be 10 cycles (binary) or 7 cycles (unary).
REQ-030 FSM_start SHALL be ignored while busy, and input changes after launch SHALL NOT affect the operation in progress.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and no bus_register_input_en/I0_bus_input_en pulse afterwards.
REQ-032 abort and FSM_start==START_CODE both in IDLE SHALL launch the operation (abort ignored in IDLE).
REQ-033 At no time SHALL two bus drivers (bus_register_out_en, I0_bus_output_en, alu_bus_out_en) be high together.
REQ-034 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-035 reset low SHALL immediately put the state in IDLE, all enables, busy and done at 0, register_addr at 0, alu_control at IDLE_OP, and captured fields at 0.
REQ-036 reset asserted mid-operation SHALL abandon the operation, and no write enable SHALL be asserted after release until a new launch.

Verification
REQ-037 Binary op: param1=1, param2=2, dest_sel=0, opcode=4'h3 -> reg reads at addresses 1 then 2; write to addr 1 at cycle 8; done at cycle 10.
REQ-038 Immediate plus I0 destination: param1=5, param2=0, param3=7, dest_sel=1 -> I0_bus_output_en in RD1/LAT1; WB drives I0_bus_input_en, not bus_register_input_en.
REQ-039 Unary: unary=1, param1=3 -> no latched_bus2_en pulse; done at cycle 7.
REQ-040 Launch ignored while busy: FSM_start=START_CODE held throughout -> next operation starts only after DONE->IDLE, every 11 cycles.
REQ-041 abort asserted in LAT2 -> IDLE next edge; no WB enable; no done.
REQ-042 reset low in EXE -> all outputs at reset values asynchronously; alu_control=IDLE_OP.
